// File: rtl/alu_decode_issue.sv
// Decode/issue stage for the integer ALU: decodes RV32I OP, OP-IMM and LUI,
// reads operands, tracks in-flight destinations and emits a registered issue packet.
module alu_decode_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand_a,
  output logic [XLEN-1:0] out_operand_b,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            illegal_instr
);

  localparam int unsigned OPW = 4;
  localparam int unsigned RW  = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [OPW-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OPW-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OPW-1:0] ALU_AND  = 4'b0010;
  localparam logic [OPW-1:0] ALU_OR   = 4'b0011;
  localparam logic [OPW-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OPW-1:0] ALU_SLL  = 4'b0101;
  localparam logic [OPW-1:0] ALU_SRL  = 4'b0110;
  localparam logic [OPW-1:0] ALU_SRA  = 4'b0111;
  localparam logic [OPW-1:0] ALU_SLT  = 4'b1000;
  localparam logic [OPW-1:0] ALU_SLTU = 4'b1001;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd;

  logic            dec_legal;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            dec_rd_we;
  logic [OPW-1:0]  dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             stall;
  logic             accept;
  logic             issue;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  // funct3 to ALU op for the non-alternate encodings shared by OP and OP-IMM
  function automatic logic [OPW-1:0] base_op(input logic [2:0] f3);
    logic [OPW-1:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction decode and operand selection
  always_comb begin
    dec_legal = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    dec_op    = ALU_ADD;
    dec_a     = rf_rs1_data;
    dec_b     = rf_rs2_data;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_op   = base_op(funct3);
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_op    = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_op    = ALU_SRA;
          end
        end
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        dec_op   = base_op(funct3);
        dec_b    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        if (funct3 == 3'b001) begin
          dec_legal = (funct7 == F7_BASE);
          dec_b     = XLEN'(in_instr[24:20]);
        end else if (funct3 == 3'b101) begin
          dec_b = XLEN'(in_instr[24:20]);
          if (funct7 == F7_BASE) begin
            dec_legal = 1'b1;
          end else if (funct7 == F7_ALT) begin
            dec_legal = 1'b1;
            dec_op    = ALU_SRA;
          end
        end else begin
          dec_legal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_ADD;
        dec_a     = '0;
        dec_b     = XLEN'({in_instr[31:12], 12'b0});
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign dec_rd_we = dec_legal && (rd != '0);

  // RAW on sources and WAW on destination; x0 never marked busy
  assign stall = (uses_rs1 && busy_q[rs1]) ||
                 (uses_rs2 && busy_q[rs2]) ||
                 (dec_rd_we && busy_q[rd]);

  assign in_ready = !flush && (!out_valid || out_ready) && (!dec_legal || !stall);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && dec_legal;

  // Scoreboard next state: clear on writeback, set on issue (set wins)
  always_comb begin
    busy_nxt = busy_q;
    if (wb_valid) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (issue && dec_rd_we) begin
      busy_nxt[rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    if (flush) begin
      busy_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= accept && !dec_legal;
    end
  end

  // Issue packet register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_operand_a <= '0;
      out_operand_b <= '0;
      out_alu_op    <= '0;
      out_rd        <= '0;
      out_rd_we     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_operand_a <= dec_a;
      out_operand_b <= dec_b;
      out_alu_op    <= dec_op;
      out_rd        <= rd;
      out_rd_we     <= dec_rd_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_issue.sv
// Scoreboard bench for alu_decode_issue: directed instructions with hand-computed packets,
// checked by an independent monitor on every output handshake.
module tb_alu_decode_issue;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        illegal_instr;

  logic [31:0] rf [32];
  pkt_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  alu_decode_issue #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand_a(out_operand_a), .out_operand_b(out_operand_b),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .illegal_instr(illegal_instr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [4:0] rd, input logic we);
    pkt_t p;
    p.a = a; p.b = b; p.op = op; p.rd = rd; p.we = we;
    return p;
  endfunction

  // Monitor: every completed output handshake is matched against the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_packet: got rd %0d op %0d, expected no packet", out_rd, out_alu_op);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        check("pkt_operand_a", out_operand_a, e.a);
        check("pkt_operand_b", out_operand_b, e.b);
        check("pkt_alu_op", 32'(out_alu_op), 32'(e.op));
        check("pkt_rd", 32'(out_rd), 32'(e.rd));
        check("pkt_rd_we", 32'(out_rd_we), 32'(e.we));
      end
    end
  end

  // Present an instruction and wait (bounded) for acceptance
  task automatic issue(input logic [31:0] instr, input pkt_t e);
    int k;
    in_valid = 1'b1;
    in_instr = instr;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: instr 0x%08h never accepted, expected accept", instr);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Present an instruction that must be accepted in its first cycle
  task automatic issue_now(input logic [31:0] instr, input pkt_t e, input string name);
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    check(name, 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_illegal(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    check("illegal_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("illegal_pulse", 32'(illegal_instr), 32'd1);
    check("illegal_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("illegal_pulse_end", 32'(illegal_instr), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[3] = 32'h100;

    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_operand_a", out_operand_a, 32'd0);
    check("reset_operand_b", out_operand_b, 32'd0);
    check("reset_rd", 32'(out_rd), 32'd0);
    check("reset_illegal", 32'(illegal_instr), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    in_instr = 32'h002081B3;
    #1;
    check("rs1_addr", 32'(rf_rs1_addr), 32'd1);
    check("rs2_addr", 32'(rf_rs2_addr), 32'd2);

    // Basic decode: ADD, ADDI with negative immediate, SRAI
    issue(32'h002081B3, mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1));
    issue(32'hFFF00293, mk(32'd0, 32'hFFFF_FFFF, 4'b0000, 5'd5, 1'b1));
    issue(32'h4040D313, mk(32'd5, 32'd4, 4'b0111, 5'd6, 1'b1));

    // RAW on x3 held until the cycle after writeback
    in_valid = 1'b1;
    in_instr = 32'h00118233;
    repeat (3) begin
      @(negedge clk);
      check("raw_stall_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    @(negedge clk);
    check("raw_wb_cycle_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    check("raw_release_ready", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(mk(32'h100, 32'd5, 4'b0000, 5'd4, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // Backpressure then back-to-back handover
    out_ready = 1'b0;
    issue(32'h0020E3B3, mk(32'd5, 32'd7, 4'b0011, 5'd7, 1'b1));
    in_valid = 1'b1;
    in_instr = 32'h0020C433;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_operand_a", out_operand_a, 32'd5);
      check("bp_alu_op", 32'(out_alu_op), 32'd3);
      check("bp_rd", 32'(out_rd), 32'd7);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("handover_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(mk(32'd5, 32'd7, 4'b0100, 5'd8, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("handover_valid", 32'(out_valid), 32'd1);
    check("handover_rd", 32'(out_rd), 32'd8);
    idle(2);

    // Illegal encodings; the second names rd=x3 and must not mark it busy
    issue_illegal(32'h0000007F);
    issue_illegal(32'h8020F1B3);
    issue_now(32'h002184B3, mk(32'h100, 32'd7, 4'b0000, 5'd9, 1'b1), "illegal_no_busy");

    // SUB, LUI, write to x0, SLTIU with negative immediate
    issue(32'h40208533, mk(32'd5, 32'd7, 4'b0001, 5'd10, 1'b1));
    issue(32'h123455B7, mk(32'd0, 32'h1234_5000, 4'b0000, 5'd11, 1'b1));
    issue(32'h00108013, mk(32'd5, 32'd1, 4'b0000, 5'd0, 1'b0));
    issue(32'hFFE0B613, mk(32'd5, 32'hFFFF_FFFE, 4'b1001, 5'd12, 1'b1));
    idle(2);

    // Flush drops the held packet and clears the scoreboard (x3, x4 busy beforehand)
    out_ready = 1'b0;
    issue(32'h002081B3, mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1));
    check("flush_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    issue_now(32'h00118233, mk(32'h100, 32'd5, 4'b0000, 5'd4, 1'b1), "flush_sb_clear");

    // Asynchronous reset mid-cycle with a packet held
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_rd", 32'(out_rd), 32'd0);
    check("async_reset_operand_a", out_operand_a, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue_now(32'h00118233, mk(32'h100, 32'd5, 4'b0000, 5'd4, 1'b1), "reset_sb_clear");
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
